// File: rtl/game_input_pkg.sv
// Shared definitions for the game input conditioning blocks: time base, counter sizing, event codes.
package game_input_pkg;

  localparam int US_PER_S = 1_000_000;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'd0,
    EVT_PRESS   = 2'd1,
    EVT_RELEASE = 2'd2,
    EVT_REPEAT  = 2'd3
  } btn_evt_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < 32'(value)) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Width of a counter holding 0..span-1, never narrower than one bit.
  function automatic int ctrWidth(input int span);
    int w;
    w = clog2(span);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/game_button_debounce_if.sv
// Button-conditioner bus: raw pins in, debounced levels, edge pulses and 1 us strobe out.
interface game_button_debounce_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0] iBTN;
  logic [N_CH-1:0] oLEVEL;
  logic [N_CH-1:0] oPRESS;
  logic [N_CH-1:0] oRELEASE;
  logic            oTICK;

  modport master (
    output iBTN,
    input  oLEVEL,
    input  oPRESS,
    input  oRELEASE,
    input  oTICK
  );

  modport slave (
    input  iBTN,
    output oLEVEL,
    output oPRESS,
    output oRELEASE,
    output oTICK
  );

endinterface

// File: rtl/game_btn_channel.sv
// One button channel: pin synchroniser, tick-based debounce window, press/release pulse generation.
// GAME_BTN_AUTOREPEAT_EN adds the held-button auto-repeat counter.
module game_btn_channel
  import game_input_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_US   = 10_000,
  parameter int ACTIVE_LOW    = 1
`ifdef GAME_BTN_AUTOREPEAT_EN
  ,
  parameter int RPT_DELAY_US  = 400_000,
  parameter int RPT_PERIOD_US = 100_000
`endif
) (
  input  logic iCLK,
  input  logic iRESETn,
  input  logic iTick,
  input  logic iPin,
  output logic oLevel,
  output logic oPress,
  output logic oRelease
);

  localparam int              DB_W     = ctrWidth(DEBOUNCE_US);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_US - 1);
  localparam logic            IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [SYNC_STAGES-1:0] syncChain_r;
  logic [DB_W-1:0]        dbCnt_r;
  logic [DB_W-1:0]        dbNext_s;
  logic                   level_r;
  logic                   press_r;
  logic                   release_r;
  logic                   pressed_s;
  btn_evt_t               debEvt_s;
  btn_evt_t               evt_s;

  // Pin synchroniser; reset loads the idle pin level so no phantom edge follows reset.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      syncChain_r <= {SYNC_STAGES{IDLE_PIN}};
    end else begin
      syncChain_r <= {syncChain_r[SYNC_STAGES-2:0], iPin};
    end
  end

  assign pressed_s = syncChain_r[SYNC_STAGES-1] ^ IDLE_PIN;

  // Debounce window: any agreement with the current level restarts the count.
  always_comb begin
    debEvt_s = EVT_NONE;
    dbNext_s = dbCnt_r;
    if (pressed_s == level_r) begin
      dbNext_s = '0;
    end else if (iTick) begin
      if (dbCnt_r == DB_LAST) begin
        dbNext_s = '0;
        debEvt_s = pressed_s ? EVT_PRESS : EVT_RELEASE;
      end else begin
        dbNext_s = dbCnt_r + 1'b1;
      end
    end else begin
      dbNext_s = dbCnt_r;
    end
  end

`ifdef GAME_BTN_AUTOREPEAT_EN
  localparam int              RPT_SPAN     = (RPT_DELAY_US > RPT_PERIOD_US) ? RPT_DELAY_US : RPT_PERIOD_US;
  localparam int              RPT_W        = ctrWidth(RPT_SPAN);
  localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(RPT_DELAY_US - 1);
  localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(RPT_PERIOD_US - 1);

  logic [RPT_W-1:0] rptCnt_r;
  logic [RPT_W-1:0] rptNext_s;
  logic             rptArmed_r;
  logic             armedNext_s;
  logic             rptFire_s;

  // Auto-repeat: first interval is the delay, later intervals the period; a releasing edge wins.
  always_comb begin
    rptNext_s   = rptCnt_r;
    armedNext_s = rptArmed_r;
    rptFire_s   = 1'b0;
    if (!level_r || (debEvt_s == EVT_RELEASE)) begin
      rptNext_s   = '0;
      armedNext_s = 1'b0;
    end else if (iTick) begin
      if (rptCnt_r == (rptArmed_r ? RPT_PER_LAST : RPT_DLY_LAST)) begin
        rptFire_s   = 1'b1;
        rptNext_s   = '0;
        armedNext_s = 1'b1;
      end else begin
        rptNext_s = rptCnt_r + 1'b1;
      end
    end else begin
      rptNext_s = rptCnt_r;
    end
  end

  // Repeat counter state.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      rptCnt_r   <= '0;
      rptArmed_r <= 1'b0;
    end else begin
      rptCnt_r   <= rptNext_s;
      rptArmed_r <= armedNext_s;
    end
  end

  // Merge debounce edges with repeat strobes into one event.
  always_comb begin
    evt_s = debEvt_s;
    if ((debEvt_s == EVT_NONE) && rptFire_s) begin
      evt_s = EVT_REPEAT;
    end else begin
      evt_s = debEvt_s;
    end
  end
`else
  assign evt_s = debEvt_s;
`endif

  // Level, debounce count and one-cycle pulses, all registered together.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      dbCnt_r   <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      dbCnt_r   <= dbNext_s;
      press_r   <= (evt_s == EVT_PRESS) || (evt_s == EVT_REPEAT);
      release_r <= (evt_s == EVT_RELEASE);
      case (evt_s)
        EVT_PRESS:   level_r <= 1'b1;
        EVT_RELEASE: level_r <= 1'b0;
        default:     level_r <= level_r;
      endcase
    end
  end

  assign oLevel   = level_r;
  assign oPress   = press_r;
  assign oRelease = release_r;

endmodule

// File: rtl/game_button_debounce.sv
// Button conditioner for the VGA game: shared 1 us prescaler feeding N_CH debounce channels.
// Defining GAME_BTN_AUTOREPEAT_EN enables held-button auto-repeat press pulses.
module game_button_debounce
  import game_input_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CLK_HZ        = 120_000_000,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_US   = 10_000,
  parameter int ACTIVE_LOW    = 1,
  parameter int RPT_DELAY_US  = 400_000,
  parameter int RPT_PERIOD_US = 100_000
) (
  input  logic                  iCLK,
  input  logic                  iRESETn,
  game_button_debounce_if.slave btnBus
);

  localparam int              TICK_DIV = CLK_HZ / US_PER_S;
  localparam int              PS_W     = ctrWidth(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [PS_W-1:0] PS_PRE   = PS_W'(TICK_DIV - 2);

  if ((TICK_DIV < 2) || (TICK_DIV * US_PER_S != CLK_HZ) || (SYNC_STAGES < 2) ||
      (DEBOUNCE_US < 1) || (RPT_DELAY_US < 1) || (RPT_PERIOD_US < 1)) begin : gBadParams
    $error("game_button_debounce: unsupported parameter set");
  end

  logic [1:0]      rstSync_r;
  logic            rstInt_s;
  logic [PS_W-1:0] psCnt_r;
  logic            tick_r;
  logic [N_CH-1:0] levelVec_s;
  logic [N_CH-1:0] pressVec_s;
  logic [N_CH-1:0] releaseVec_s;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      rstSync_r <= 2'b00;
    end else begin
      rstSync_r <= {rstSync_r[0], 1'b1};
    end
  end

  assign rstInt_s = rstSync_r[1];

  // Prescaler; the strobe is registered one count early so it is high while the count is at its last value.
  always_ff @(posedge iCLK or negedge rstInt_s) begin
    if (!rstInt_s) begin
      psCnt_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      psCnt_r <= (psCnt_r == PS_LAST) ? '0 : psCnt_r + 1'b1;
      tick_r  <= (psCnt_r == PS_PRE);
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : gCh
    game_btn_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_US   (DEBOUNCE_US),
      .ACTIVE_LOW    (ACTIVE_LOW)
`ifdef GAME_BTN_AUTOREPEAT_EN
      ,
      .RPT_DELAY_US  (RPT_DELAY_US),
      .RPT_PERIOD_US (RPT_PERIOD_US)
`endif
    ) uCh (
      .iCLK     (iCLK),
      .iRESETn  (rstInt_s),
      .iTick    (tick_r),
      .iPin     (btnBus.iBTN[gi]),
      .oLevel   (levelVec_s[gi]),
      .oPress   (pressVec_s[gi]),
      .oRelease (releaseVec_s[gi])
    );
  end

  assign btnBus.oLEVEL   = levelVec_s;
  assign btnBus.oPRESS   = pressVec_s;
  assign btnBus.oRELEASE = releaseVec_s;
  assign btnBus.oTICK    = tick_r;

endmodule
